// File: rtl/fc_argmax.sv
// Argmax over the fc2 logit vector: snapshot on start, one signed compare per cycle, result held on valid/ready.
// Optional runner-up tracking and margin output enabled by defining FC_ARGMAX_MARGIN_EN.
module fc_argmax #(
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned IDX_W       = (NUM_CLASSES > 2) ? $clog2(NUM_CLASSES) : 1
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 start,
  input  logic [NUM_CLASSES-1:0][DATA_W-1:0]   logits,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 result_valid,
  input  logic                                 result_ready,
  output logic [IDX_W-1:0]                     class_idx,
  output logic [DATA_W-1:0]                    max_logit
`ifdef FC_ARGMAX_MARGIN_EN
  ,
  output logic [DATA_W:0]                      margin
`endif
);

  localparam int unsigned LAST = NUM_CLASSES - 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic signed [DATA_W-1:0]  snap_q [NUM_CLASSES];
  logic signed [DATA_W-1:0]  snap_d [NUM_CLASSES];
  logic signed [DATA_W-1:0]  best_q, best_d;
  logic [IDX_W-1:0]          best_idx_q, best_idx_d;
  logic [IDX_W-1:0]          ptr_q, ptr_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      valid_q, valid_d;
  logic [IDX_W-1:0]          class_idx_q, class_idx_d;
  logic [DATA_W-1:0]         max_logit_q, max_logit_d;

  logic signed [DATA_W-1:0]  cur_c;
  logic                      take_c;
  logic signed [DATA_W-1:0]  cand_best_c;
  logic [IDX_W-1:0]          cand_idx_c;

  // Current element vs running best; strict compare keeps the lower index on ties
  assign cur_c       = snap_q[ptr_q];
  assign take_c      = cur_c > best_q;
  assign cand_best_c = take_c ? cur_c : best_q;
  assign cand_idx_c  = take_c ? ptr_q : best_idx_q;

`ifdef FC_ARGMAX_MARGIN_EN
  logic signed [DATA_W-1:0]  second_q, second_d;
  logic [DATA_W:0]           margin_q, margin_d;
  logic signed [DATA_W-1:0]  cand_second_c;
  logic [DATA_W:0]           margin_c;

  // Displaced best becomes runner-up; otherwise runner-up only grows (equal values count)
  assign cand_second_c = take_c ? best_q : ((cur_c > second_q) ? cur_c : second_q);
  assign margin_c      = {cand_best_c[DATA_W-1], cand_best_c}
                       - {cand_second_c[DATA_W-1], cand_second_c};
  assign margin        = margin_q;
`endif

  assign busy         = busy_q;
  assign done         = done_q;
  assign result_valid = valid_q;
  assign class_idx    = class_idx_q;
  assign max_logit    = max_logit_q;

  // Next-state and register update logic
  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    best_d      = best_q;
    best_idx_d  = best_idx_q;
    ptr_d       = ptr_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    valid_d     = valid_q;
    class_idx_d = class_idx_q;
    max_logit_d = max_logit_q;
`ifdef FC_ARGMAX_MARGIN_EN
    second_d    = second_q;
    margin_d    = margin_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          for (int i = 0; i < int'(NUM_CLASSES); i++) begin
            snap_d[i] = logits[i];
          end
          best_d     = logits[0];
          best_idx_d = '0;
          ptr_d      = IDX_W'(1);
          busy_d     = 1'b1;
`ifdef FC_ARGMAX_MARGIN_EN
          second_d   = {1'b1, {(DATA_W-1){1'b0}}};
`endif
          state_d    = S_SCAN;
        end
      end
      S_SCAN: begin
        best_d     = cand_best_c;
        best_idx_d = cand_idx_c;
        ptr_d      = ptr_q + IDX_W'(1);
`ifdef FC_ARGMAX_MARGIN_EN
        second_d   = cand_second_c;
`endif
        if (ptr_q == IDX_W'(LAST)) begin
          class_idx_d = cand_idx_c;
          max_logit_d = cand_best_c;
`ifdef FC_ARGMAX_MARGIN_EN
          margin_d    = margin_c;
`endif
          valid_d     = 1'b1;
          done_d      = 1'b1;
          state_d     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (result_ready) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      for (int i = 0; i < int'(NUM_CLASSES); i++) begin
        snap_q[i] <= '0;
      end
      best_q      <= '0;
      best_idx_q  <= '0;
      ptr_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      valid_q     <= 1'b0;
      class_idx_q <= '0;
      max_logit_q <= '0;
`ifdef FC_ARGMAX_MARGIN_EN
      second_q    <= '0;
      margin_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      snap_q      <= snap_d;
      best_q      <= best_d;
      best_idx_q  <= best_idx_d;
      ptr_q       <= ptr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      valid_q     <= valid_d;
      class_idx_q <= class_idx_d;
      max_logit_q <= max_logit_d;
`ifdef FC_ARGMAX_MARGIN_EN
      second_q    <= second_d;
      margin_q    <= margin_d;
`endif
    end
  end

endmodule

// File: tb/tb_fc_argmax.sv
// Bench for fc_argmax: reference argmax model with latency tracking, per-cycle compare, directed runs.
// Margin checks are included when FC_ARGMAX_MARGIN_EN is defined.
module tb_fc_argmax;

  localparam int unsigned NC = 10;
  localparam int unsigned DW = 32;
  localparam int unsigned IW = 4;
  localparam int IMIN = 32'sh8000_0000;
  localparam int IMAX = 32'sh7fff_ffff;

  logic                     clk = 1'b0;
  logic                     reset_n = 1'b0;
  logic                     start = 1'b0;
  logic                     result_ready = 1'b0;
  logic [NC-1:0][DW-1:0]    logits = '0;
  logic                     busy, done, result_valid;
  logic [IW-1:0]            class_idx;
  logic [DW-1:0]            max_logit;
`ifdef FC_ARGMAX_MARGIN_EN
  logic [DW:0]              margin;
`endif

  int total = 0;
  int bad   = 0;
  int vals [NC];

  always #5 clk = ~clk;

  fc_argmax #(.NUM_CLASSES(NC), .DATA_W(DW), .IDX_W(IW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .logits       (logits),
    .busy         (busy),
    .done         (done),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .class_idx    (class_idx),
    .max_logit    (max_logit)
`ifdef FC_ARGMAX_MARGIN_EN
    ,
    .margin       (margin)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    check(name, {32'b0, act}, {32'b0, exp});
  endtask

  // Reference: plain argmax (lowest index on ties) and largest value among the other entries
  task automatic ref_eval(input logic signed [DW-1:0] a [NC], output int idx,
                          output logic [DW-1:0] mx, output logic [DW:0] mg);
    int bi;
    longint bv, sv;
    bi = 0;
    bv = longint'(a[0]);
    for (int i = 1; i < int'(NC); i++) begin
      if (longint'(a[i]) > bv) begin
        bv = longint'(a[i]);
        bi = i;
      end
    end
    sv = longint'(IMIN);
    for (int i = 0; i < int'(NC); i++) begin
      if (i != bi && longint'(a[i]) > sv) sv = longint'(a[i]);
    end
    idx = bi;
    mx  = DW'(bv);
    mg  = (DW+1)'(bv - sv);
  endtask

  // Model: idle/scanning/holding with the result appearing NC-1 edges after the start edge
  int                     m_phase = 0;
  int                     m_cnt = 0;
  logic                   m_valid = 1'b0;
  logic                   m_done = 1'b0;
  int                     m_idx = 0;
  logic [DW-1:0]          m_max = '0;
  logic [DW:0]            m_margin = '0;
  int                     p_idx;
  logic [DW-1:0]          p_max;
  logic [DW:0]            p_margin;
  logic signed [DW-1:0]   snapv [NC];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_phase = 0; m_cnt = 0; m_valid = 1'b0; m_done = 1'b0;
      m_idx = 0; m_max = '0; m_margin = '0;
    end else begin
      m_done = 1'b0;
      case (m_phase)
        0: if (start) begin
          for (int i = 0; i < int'(NC); i++) snapv[i] = logits[i];
          ref_eval(snapv, p_idx, p_max, p_margin);
          m_cnt = int'(NC) - 1;
          m_phase = 1;
        end
        1: begin
          m_cnt--;
          if (m_cnt == 0) begin
            m_phase = 2; m_valid = 1'b1; m_done = 1'b1;
            m_idx = p_idx; m_max = p_max; m_margin = p_margin;
          end
        end
        default: if (result_ready) begin
          m_valid = 1'b0;
          m_phase = 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    check("busy", {63'b0, busy}, {63'b0, (m_phase != 0)});
    check("done", {63'b0, done}, {63'b0, m_done});
    check("result_valid", {63'b0, result_valid}, {63'b0, m_valid});
    check("class_idx", {60'b0, class_idx}, 64'(m_idx));
    check32("max_logit", max_logit, m_max);
`ifdef FC_ARGMAX_MARGIN_EN
    check("margin", {31'b0, margin}, {31'b0, m_margin});
`endif
  end

  task automatic push_vals();
    for (int i = 0; i < int'(NC); i++) logits[i] = DW'(vals[i]);
  endtask

  task automatic pulse_start(input logic pre_ready);
    @(posedge clk); #2;
    push_vals();
    start = 1'b1;
    result_ready = pre_ready;
    @(posedge clk); #2;
    start = 1'b0;
    for (int i = 0; i < int'(NC); i++) logits[i] = DW'($urandom);
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!result_valid && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic run(input int exp_idx, input int exp_max, input logic pre_ready);
    int cyc;
    pulse_start(pre_ready);
    wait_valid(cyc);
    check("latency", 64'(cyc), 64'(NC - 1));
    check("done_pulse", {63'b0, done}, 64'd1);
    check32("lit_idx", {28'b0, class_idx}, exp_idx);
    check32("lit_max", max_logit, exp_max);
    if (!pre_ready) begin
      #1;
      result_ready = 1'b1;
    end
    @(posedge clk); #2;
    result_ready = 1'b0;
    check("rv_drop", {63'b0, result_valid}, 64'd0);
  endtask

  initial begin
    int cyc;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_valid", {63'b0, result_valid}, 64'd0);
    check32("rst_max", max_logit, 32'd0);
    #1;
    reset_n = 1'b1;

    vals = '{3, -1, 8, 0, 2, 5, 1, 12, 4, -7};
    run(7, 12, 1'b0);
`ifdef FC_ARGMAX_MARGIN_EN
    check("lit_margin_t1", {31'b0, margin}, 64'd4);
`endif

    vals = '{1, 2, 50, 3, 4, 50, 5, 6, 7, 8};
    run(2, 50, 1'b1);

    vals = '{-5, -6, -7, -8, -9, -10, -11, -12, -13, -14};
    run(0, -5, 1'b0);

    vals = '{IMIN, IMIN, IMIN, IMIN, IMIN, IMIN, IMIN, IMIN, IMIN, IMAX};
    run(9, IMAX, 1'b0);

    // Backpressure: hold for 6 cycles with start pulses and changing logits
    vals = '{9, 1, 2, 30, 4, 5, 6, 7, 8, 0};
    pulse_start(1'b0);
    wait_valid(cyc);
    check("bp_latency", 64'(cyc), 64'(NC - 1));
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #2;
      start = (k == 1 || k == 3);
      for (int i = 0; i < int'(NC); i++) logits[i] = DW'($urandom);
      check32("bp_idx", {28'b0, class_idx}, 32'd3);
      check32("bp_max", max_logit, 32'd30);
      check("bp_valid", {63'b0, result_valid}, 64'd1);
    end
    start = 1'b1;
    result_ready = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    result_ready = 1'b0;
    check("bp_drop", {63'b0, result_valid}, 64'd0);
    check("bp_idle", {63'b0, busy}, 64'd0);
    repeat (3) @(posedge clk);
    #2;
    check("bp_norestart", {63'b0, busy}, 64'd0);
    check32("bp_keep_max", max_logit, 32'd30);

    // Asynchronous reset in the middle of a scan
    vals = '{3, -1, 8, 0, 2, 5, 1, 12, 4, -7};
    pulse_start(1'b0);
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_busy", {63'b0, busy}, 64'd0);
    check("ar_valid", {63'b0, result_valid}, 64'd0);
    check32("ar_idx", {28'b0, class_idx}, 32'd0);
    check32("ar_max", max_logit, 32'd0);
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b1;
    vals = '{3, 20, 8, 0, 2, 5, 1, 12, 4, -7};
    run(1, 20, 1'b0);

`ifdef FC_ARGMAX_MARGIN_EN
    vals = '{10, 40, 100, -3, 0, 7, 39, 1, 2, 3};
    run(2, 100, 1'b0);
    check("lit_margin_60", {31'b0, margin}, 64'd60);
    vals = '{IMAX, IMIN, IMIN, IMIN, IMIN, IMIN, IMIN, IMIN, IMIN, IMIN};
    run(0, IMAX, 1'b0);
    check("lit_margin_ext", {31'b0, margin}, 64'd4294967295);
    vals = '{77, 77, 1, 2, 3, 4, 5, 6, 7, 8};
    run(0, 77, 1'b0);
    check("lit_margin_tie", {31'b0, margin}, 64'd0);
`endif

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
